sum_frame_accum: RTL
====================

# sum_frame_accum

Downstream consumer of the dual 33-bit adder stage: takes its two sum results (`res1` and `res2`) per beat under a valid/ready handshake. Accumulates each stream into a wide register over a frame of `BEAT_CNT` beats, or fewer if a beat arrives with `in_last` high. Emits both frame totals, the beat count and a sticky overflow flag through a registered valid/ready output. Sits between the adder stage and the result-collection logic.

## Interface
- `DATA_W`, 33: width of each input sum; matches the upstream adder's result width.
- `ACC_W`, 64: accumulator and output-total width; must be ≥ `DATA_W`.
- `BEAT_CNT`, 8: beats per full frame; legal range 1..255.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: input beat present.
- `in_ready` output 1: block accepts a beat this cycle.
- `in_res1` input `DATA_W`: first sum, unsigned.
- `in_res2` input `DATA_W`: second sum, unsigned.
- `in_last` input 1: this beat closes the frame early.
- `out_valid` output 1: frame result held.
- `out_ready` input 1: consumer takes the result.
- `out_sum1` output `ACC_W`: frame total of `in_res1`.
- `out_sum2` output `ACC_W`: frame total of `in_res2`.
- `out_count` output 8: number of beats in the frame (1..`BEAT_CNT`).
- `out_ovf` output 1: an accumulator wrapped during this frame.

## Operation
- Two states: ACCUM and EMIT. Reset state is ACCUM.
- `in_ready` is 1 exactly when the state is ACCUM. It is a pure decode of the state and has no combinational path from `in_valid` or `out_ready`.
- **Accept condition:** a beat is accepted on a cycle where `in_valid` and `in_ready` are both high.
- **On accept:**
  - `acc1` ← `acc1` + zero-extended `in_res1`, modulo 2^`ACC_W`.
  - `acc2` ← `acc2` + zero-extended `in_res2`, modulo 2^`ACC_W`.
  - `cnt` ← `cnt` + 1.
  - `ovf` is set if either addition carries out of `ACC_W` bits. It is sticky for the rest of the frame.
- **Frame close:** the frame closes on an accepted beat where `cnt` + 1 equals `BEAT_CNT`, or where `in_last` is 1. In that same cycle:
  - the updated accumulators, count and overflow flag are loaded into the output registers;
  - the state moves to EMIT.
- `in_last` together with the `BEAT_CNT`-th beat is a single close; the count is `BEAT_CNT`.
- **EMIT:** `out_valid` is 1 and the output fields are stable.
  - On `out_valid` and `out_ready`: `acc1`, `acc2`, `cnt` and `ovf` clear, `out_valid` drops, and the state returns to ACCUM.
  - While `out_ready` is low, EMIT holds indefinitely and no input beats are taken.
- Input data is ignored when `in_valid` is low. No frame with zero beats is ever emitted.
- **Reset values:**
  - `out_valid` 0, `in_ready` 1 (ACCUM).
  - `out_sum1` 0, `out_sum2` 0, `out_count` 0, `out_ovf` 0.
  - Internal accumulators, counter and flag are 0.
- **Reset mid-frame or mid-EMIT:** all state clears immediately (asynchronous). The partial or pending frame is discarded and never emitted.

## Timing
- **Latency:** the closing beat is accepted at edge N; `out_valid` is high after edge N and observable in cycle N+1.
- **Output to next beat:** the output handshake completes at edge M; `in_ready` is 1 in cycle M+1.
- **Throughput:** a full frame takes `BEAT_CNT` + 1 cycles at best, i.e. one bubble per frame when `out_ready` is held at 1.
- All outputs come straight from registers; none depend combinationally on inputs.
- Release of `rst` is synchronised externally; the block needs no internal reset synchroniser.

## Test plan
- **Full frame, default parameters:** 8 back-to-back beats, `in_res1` = 1..8, `in_res2` = 0x1_FFFF_FFFF each, `out_ready` = 1.
  - Required: `out_sum1` = 36, `out_sum2` = 0xF_FFFF_FFF8, `out_count` = 8, `out_ovf` = 0.
  - `out_valid` high one cycle after beat 8; `in_ready` back to 1 the cycle after that.
- **Early close:** 3 beats of (5, 7) with `in_last` on the 3rd.
  - Required: `out_sum1` = 15, `out_sum2` = 21, `out_count` = 3.
  - The next frame starts from zero: a following single beat (2, 2) with `in_last` gives sums 2/2, count 1.
- **Output backpressure:** complete a frame, then hold `out_ready` = 0 for 5 cycles while `in_valid` = 1.
  - Required: `in_ready` = 0 and the outputs stay stable for all 5 cycles; no beat is lost.
  - Raising `out_ready` completes the handshake, and the held beat is accepted in the following cycle.
- **Overflow wrap, `ACC_W` = 34, `BEAT_CNT` = 4:** four beats of `in_res2` = 0x1_FFFF_FFFF.
  - Required: `out_sum2` = 0x3_FFFF_FFFC and `out_ovf` = 1.
  - The next frame, with small values, reports `out_ovf` = 0.
- **Input gaps:** 8 beats with `in_valid` low on alternate cycles, and junk data on the data inputs while `in_valid` is low.
  - Required: totals are identical to scenario 1.
- **Asynchronous reset:**
  - Assert `rst` mid-clock-cycle after 5 beats: all outputs are 0 immediately and `in_ready` = 1.
  - After release, 8 fresh beats of (1, 1) give sums 8/8, count 8; no stale data appears.
  - Repeat the reset during EMIT: `out_valid` drops immediately.

Source files
------------

// File: rtl/sum_frame_accum.sv
// sum_frame_accum: per-frame accumulator for the dual 33-bit adder stage.
// Sums in_res1 and in_res2 over a frame of BEAT_CNT beats, or fewer if a beat
// arrives with in_last high. The frame totals, the beat count and a sticky
// overflow flag are held in output registers until the consumer accepts them.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input beat handshake (in_ready = state is ACCUM)
//   in_res1, in_res2    unsigned sums, DATA_W bits each
//   in_last             beat closes the frame early
//   out_valid/out_ready result handshake (out_valid = state is EMIT)
//   out_sum1, out_sum2  frame totals modulo 2^ACC_W
//   out_count           beats in the frame (1..BEAT_CNT)
//   out_ovf             an accumulator wrapped during the frame
module sum_frame_accum #(
  parameter int unsigned DATA_W   = 33,
  parameter int unsigned ACC_W    = 64,
  parameter int unsigned BEAT_CNT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_res1,
  input  logic [DATA_W-1:0] in_res2,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum1,
  output logic [ACC_W-1:0]  out_sum2,
  output logic [7:0]        out_count,
  output logic              out_ovf
);

  localparam logic [7:0] BEAT_LAST = 8'(BEAT_CNT);

  typedef enum logic {StAccum, StEmit} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc1_q, acc1_d, acc2_q, acc2_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   osum1_q, osum1_d, osum2_q, osum2_d;
  logic [7:0]         ocnt_q, ocnt_d;
  logic               oovf_q, oovf_d;

  logic [ACC_W:0]     ext1, ext2, add1, add2;
  logic [7:0]         cnt_inc;
  logic               accept, close;

  always_comb begin
    // One extra bit on the adders captures the carry out of ACC_W.
    ext1                = '0;
    ext2                = '0;
    ext1[DATA_W-1:0]    = in_res1;
    ext2[DATA_W-1:0]    = in_res2;
    add1                = {1'b0, acc1_q} + ext1;
    add2                = {1'b0, acc2_q} + ext2;
    cnt_inc             = cnt_q + 8'd1;
    accept              = in_valid && (state_q == StAccum);
    close               = accept && ((cnt_inc == BEAT_LAST) || in_last);

    state_d = state_q;
    acc1_d  = acc1_q;
    acc2_d  = acc2_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    osum1_d = osum1_q;
    osum2_d = osum2_q;
    ocnt_d  = ocnt_q;
    oovf_d  = oovf_q;

    unique case (state_q)
      StAccum: begin
        if (accept) begin
          acc1_d = add1[ACC_W-1:0];
          acc2_d = add2[ACC_W-1:0];
          cnt_d  = cnt_inc;
          ovf_d  = ovf_q | add1[ACC_W] | add2[ACC_W];
          if (close) begin
            osum1_d = add1[ACC_W-1:0];
            osum2_d = add2[ACC_W-1:0];
            ocnt_d  = cnt_inc;
            oovf_d  = ovf_q | add1[ACC_W] | add2[ACC_W];
            state_d = StEmit;
          end
        end
      end
      StEmit: begin
        if (out_ready) begin
          acc1_d  = '0;
          acc2_d  = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = StAccum;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StAccum;
      acc1_q  <= '0;
      acc2_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      osum1_q <= '0;
      osum2_q <= '0;
      ocnt_q  <= '0;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc1_q  <= acc1_d;
      acc2_q  <= acc2_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      osum1_q <= osum1_d;
      osum2_q <= osum2_d;
      ocnt_q  <= ocnt_d;
      oovf_q  <= oovf_d;
    end
  end

  assign in_ready  = (state_q == StAccum);
  assign out_valid = (state_q == StEmit);
  assign out_sum1  = osum1_q;
  assign out_sum2  = osum2_q;
  assign out_count = ocnt_q;
  assign out_ovf   = oovf_q;

endmodule
